// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time, single-cycle ram access, registered response.
// Optional alignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic [31:0] ram_rd_addr_o,
    output logic        ram_rd_en_o,
    output logic [2:0]  ram_rd_size_o,
    input  logic [31:0] ram_rd_data_i,
    output logic [31:0] ram_wd_addr_o,
    output logic        ram_wd_en_o,
    output logic [2:0]  ram_wd_size_o,
    output logic [31:0] ram_wd_data_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [2:0]  r_size;
    logic [1:0]  r_err;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;

    logic [2:0]  w_size;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_oor;
    logic [1:0]  w_err;
    logic [31:0] w_load_ext;
    logic        w_accept;

    always_comb begin
        unique case (req_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            2'b10:   w_size = 3'd4;
            default: w_size = 3'd0;
        endcase
    end

    always_comb begin
        w_illegal = 1'b1;
        if (req_we) begin
            w_illegal = (req_funct3 > 3'd2);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == 3'd2) && req_addr[0]) ||
                        ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign w_oor = ({1'b0, req_addr} + {30'd0, w_size}) > 33'(MEM_BYTES);

    assign w_err = w_illegal  ? 2'd3 :
                   w_misalign ? 2'd1 :
                   w_oor      ? 2'd2 : 2'd0;

    assign w_accept = (r_state == IDLE) && req_valid;

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{ram_rd_data_i[7]}}, ram_rd_data_i[7:0]};
            3'b001:  w_load_ext = {{16{ram_rd_data_i[15]}}, ram_rd_data_i[15:0]};
            3'b100:  w_load_ext = {24'd0, ram_rd_data_i[7:0]};
            3'b101:  w_load_ext = {16'd0, ram_rd_data_i[15:0]};
            default: w_load_ext = ram_rd_data_i;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_err == 2'd0) ? ACCESS : RESP;
                end
            end
            ACCESS:  w_state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rd         <= 5'd0;
            r_size       <= 3'd0;
            r_err        <= 2'd0;
            r_resp_rdata <= 32'd0;
            r_resp_rd    <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rd     <= req_rd;
                r_size   <= w_size;
                r_err    <= w_err;
                if (w_err != 2'd0) begin
                    r_resp_rdata <= 32'd0;
                    r_resp_rd    <= 5'd0;
                end
            end
            if (r_state == ACCESS) begin
                r_resp_rdata <= r_we ? 32'd0 : w_load_ext;
                r_resp_rd    <= r_we ? 5'd0 : r_rd;
            end
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = (r_state == RESP);
    assign resp_rdata    = r_resp_rdata;
    assign resp_rd       = r_resp_rd;
    assign resp_err      = r_err;

    assign ram_rd_en_o   = (r_state == ACCESS) && !r_we;
    assign ram_wd_en_o   = (r_state == ACCESS) && r_we;
    assign ram_rd_addr_o = r_addr;
    assign ram_wd_addr_o = r_addr;
    assign ram_rd_size_o = r_size;
    assign ram_wd_size_o = r_size;
    assign ram_wd_data_o = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan table, hold/reset scenarios and random ops
// compared against a byte-array memory model.
module tb_lsu;

    localparam int MEMB = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic [31:0] ram_rd_addr_o, ram_rd_data_i, ram_wd_addr_o, ram_wd_data_o;
    logic        ram_rd_en_o, ram_wd_en_o;
    logic [2:0]  ram_rd_size_o, ram_wd_size_o;

    logic [7:0] ram_mem  [0:MEMB-1];
    logic [7:0] gold_mem [0:MEMB-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_en_o(ram_rd_en_o),
        .ram_rd_size_o(ram_rd_size_o), .ram_rd_data_i(ram_rd_data_i),
        .ram_wd_addr_o(ram_wd_addr_o), .ram_wd_en_o(ram_wd_en_o),
        .ram_wd_size_o(ram_wd_size_o), .ram_wd_data_o(ram_wd_data_o)
    );

    // Byte-addressed ram: LSB-aligned little-endian read data, level-sensitive write
    always_comb begin
        ram_rd_data_i = 32'd0;
        if (ram_rd_en_o) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(ram_rd_size_o))
                    ram_rd_data_i[8*k +: 8] = ram_mem[(int'(ram_rd_addr_o[12:0]) + k) % MEMB];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_wd_en_o) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(ram_wd_size_o))
                    ram_mem[(int'(ram_wd_addr_o[12:0]) + k) % MEMB] <= ram_wd_data_o[8*k +: 8];
            end
        end
    end

    // Reference model: decode, check, and perform the access on gold_mem
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rd,
                            output logic [1:0] err, output logic [31:0] rdata,
                            output logic [4:0] erd);
        int  size;
        bit  legal;
        bit  mis;
        longint unsigned top;
        logic [31:0] val;
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
        top   = longint'(addr) + longint'(size);
        rdata = 32'd0;
        erd   = 5'd0;
        if (!legal) err = 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
        else if (mis) err = 2'd1;
`endif
        else if (top > longint'(MEMB)) err = 2'd2;
        else begin
            err = 2'd0;
            if (we) begin
                for (int k = 0; k < size; k++) gold_mem[int'(addr) + k] = 8'((wd >> (8 * k)));
            end else begin
                val = 32'd0;
                for (int k = 0; k < size; k++)
                    val = val + (32'(gold_mem[int'(addr) + k]) << (8 * k));
                if (f3 == 3'd0 && val >= 32'd128)   val = val - 32'd256;
                if (f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
                rdata = val;
                erd   = rd;
            end
        end
        if (mis) size = size; // alignment flag is only consulted when the trap is built in
    endtask

    // Drives one request from #1 after an edge; returns #1 after the edge where resp_valid is seen
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output int lat, output logic [31:0] o_rdata, output logic [4:0] o_rd,
                         output logic [1:0] o_err, output int n_rden, output int n_wden);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
        n_rden = 0; n_wden = 0; lat = -1;
        o_rdata = 32'd0; o_rd = 5'd0; o_err = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (ram_rd_en_o) n_rden++;
            if (ram_wd_en_o) n_wden++;
            if (resp_valid) begin
                lat = c; o_rdata = resp_rdata; o_rd = resp_rd; o_err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_rd, resp_err} !== {1'b1, 1'b0, 39'd0}) begin
            n_fail++;
            $display("FAIL reset_resp: ready=%b valid=%b rdata=%h rd=%0d err=%0d want 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_rd, resp_err);
        end
        n_checks++;
        if ({ram_rd_addr_o, ram_rd_en_o, ram_rd_size_o, ram_wd_addr_o, ram_wd_en_o,
             ram_wd_size_o, ram_wd_data_o} !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_ram: rda=%h rde=%b rds=%0d wda=%h wde=%b wds=%0d wdd=%h want 0",
                     ram_rd_addr_o, ram_rd_en_o, ram_rd_size_o, ram_wd_addr_o, ram_wd_en_o,
                     ram_wd_size_o, ram_wd_data_o);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [4:0]  erd;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [15];
        int lat, nr, nw;
        logic [31:0] od, md;
        logic [4:0]  orr, mr;
        logic [1:0]  oe, me;
        tbl[0]  = '{1'b1, 3'd2, 32'h100,  32'hDEADBEEF, 5'd5,  2'd0, 32'h0,        5'd0};
        tbl[1]  = '{1'b0, 3'd2, 32'h100,  32'h0,        5'd7,  2'd0, 32'hDEADBEEF, 5'd7};
        tbl[2]  = '{1'b0, 3'd0, 32'h101,  32'h0,        5'd8,  2'd0, 32'hFFFFFFBE, 5'd8};
        tbl[3]  = '{1'b0, 3'd4, 32'h101,  32'h0,        5'd9,  2'd0, 32'h000000BE, 5'd9};
        tbl[4]  = '{1'b0, 3'd1, 32'h102,  32'h0,        5'd10, 2'd0, 32'hFFFFDEAD, 5'd10};
        tbl[5]  = '{1'b0, 3'd5, 32'h102,  32'h0,        5'd11, 2'd0, 32'h0000DEAD, 5'd11};
        tbl[6]  = '{1'b1, 3'd2, 32'h104,  32'h11223344, 5'd3,  2'd0, 32'h0,        5'd0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[7]  = '{1'b0, 3'd2, 32'h102,  32'h0,        5'd12, 2'd1, 32'h0,        5'd0};
        tbl[13] = '{1'b0, 3'd1, 32'h1FFF, 32'h0,        5'd17, 2'd1, 32'h0,        5'd0};
`else
        tbl[7]  = '{1'b0, 3'd2, 32'h102,  32'h0,        5'd12, 2'd0, 32'h3344DEAD, 5'd12};
        tbl[13] = '{1'b0, 3'd1, 32'h1FFF, 32'h0,        5'd17, 2'd2, 32'h0,        5'd0};
`endif
        tbl[8]  = '{1'b1, 3'd2, 32'h1FFE, 32'hCAFEF00D, 5'd1,  2'd2, 32'h0,        5'd0};
        tbl[9]  = '{1'b0, 3'd5, 32'h1FFE, 32'h0,        5'd13, 2'd0, 32'h0,        5'd13};
        tbl[10] = '{1'b0, 3'd3, 32'h100,  32'h0,        5'd14, 2'd3, 32'h0,        5'd0};
        tbl[11] = '{1'b1, 3'd3, 32'h100,  32'h55555555, 5'd15, 2'd3, 32'h0,        5'd0};
        tbl[12] = '{1'b0, 3'd0, 32'h1FFF, 32'h0,        5'd16, 2'd0, 32'h0,        5'd16};
        tbl[14] = '{1'b0, 3'd2, 32'h1FFC, 32'h0,        5'd18, 2'd0, 32'h0,        5'd18};
        resp_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            model_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, me, md, mr);
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, lat, od, orr, oe,
                  nr, nw);
            n_checks++;
            if ({oe, od, orr} !== {tbl[i].err, tbl[i].rdata, tbl[i].erd}) begin
                n_fail++;
                $display("FAIL dir_resp[%0d]: err=%0d rdata=%h rd=%0d want err=%0d rdata=%h rd=%0d",
                         i, oe, od, orr, tbl[i].err, tbl[i].rdata, tbl[i].erd);
            end
            n_checks++;
            if (lat !== ((tbl[i].err == 2'd0) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat,
                         (tbl[i].err == 2'd0) ? 2 : 1);
            end
            n_checks++;
            if (nw !== ((tbl[i].we && tbl[i].err == 2'd0) ? 1 : 0) ||
                nr !== ((!tbl[i].we && tbl[i].err == 2'd0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL dir_enables[%0d]: wd_en cycles=%0d rd_en cycles=%0d", i, nw, nr);
            end
            @(posedge clk); #1;
            n_checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_after_hs[%0d]: ready=%b valid=%b want 1 0", i, req_ready,
                         resp_valid);
            end
        end
    endtask

    task automatic test_hold();
        int lat, nr, nw;
        logic [31:0] od;
        logic [4:0]  orr;
        logic [1:0]  oe;
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h100, 32'h0, 5'd21, lat, od, orr, oe, nr, nw);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'($urandom % 2); req_we = 1'b0; req_funct3 = 3'd0;
            req_addr = $urandom_range(0, 255); req_rd = 5'd30;
            @(posedge clk); #1;
            n_checks++;
            if ({resp_valid, req_ready, resp_rdata, resp_rd, resp_err} !==
                {1'b1, 1'b0, 32'hDEADBEEF, 5'd21, 2'd0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b ready=%b rdata=%h rd=%0d err=%0d", c,
                         resp_valid, req_ready, resp_rdata, resp_rd, resp_err);
            end
        end
        req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1 || ram_rd_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_req_overlap: ready=%b rd_en=%b want 1 0", req_ready, ram_rd_en_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nr, nw;
        logic [31:0] od;
        logic [4:0]  orr;
        logic [1:0]  oe;
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h104, 32'h0, 5'd4, lat, od, orr, oe, nr, nw);
        n_checks++;
        if (resp_valid !== 1'b1 || od !== 32'h11223344) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b rdata=%h want 1 11223344", resp_valid, od);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_rd, resp_err, ram_rd_addr_o, ram_rd_en_o,
             ram_rd_size_o, ram_wd_addr_o, ram_wd_en_o, ram_wd_size_o, ram_wd_data_o} !==
            {1'b1, 1'b0, 143'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b valid=%b rdata=%h rd=%0d err=%0d rda=%h wda=%h",
                     req_ready, resp_valid, resp_rdata, resp_rd, resp_err, ram_rd_addr_o,
                     ram_wd_addr_o);
        end
        resp_ready = 1'b1;
    endtask

    task automatic test_random();
        int lat, nr, nw, sel;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, od, md;
        logic [4:0]  rd, orr, mr;
        logic [1:0]  oe, me;
        resp_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       addr = $urandom_range(0, MEMB - 1);
                1:       addr = 32'(MEMB - 8 + $urandom_range(0, 10));
                2:       addr = $urandom;
                default: addr = $urandom_range(0, 63);
            endcase
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            wd = $urandom;
            rd = 5'($urandom % 32);
            model_op(we, f3, addr, wd, rd, me, md, mr);
            issue(we, f3, addr, wd, rd, lat, od, orr, oe, nr, nw);
            n_checks++;
            if ({oe, od, orr} !== {me, md, mr}) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d]: we=%b f3=%0d addr=%h err=%0d rdata=%h rd=%0d want %0d %h %0d",
                         i, we, f3, addr, oe, od, orr, me, md, mr);
            end
            n_checks++;
            if (lat !== ((me == 2'd0) ? 2 : 1) || nw !== ((we && me == 2'd0) ? 1 : 0) ||
                nr !== ((!we && me == 2'd0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rnd_timing[%0d]: lat=%0d wd_en=%0d rd_en=%0d want err=%0d", i, lat,
                         nw, nr, me);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int a = 0; a < MEMB; a++) begin
            ram_mem[a]  = 8'd0;
            gold_mem[a] = 8'd0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b1;
        #1;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data `ram`. It accepts one memory request at a time over a valid/ready handshake and decodes RV32I load/store `funct3`. It drives the `ram` read or write port for exactly one cycle, then sign- or zero-extends load data and returns a registered response to writeback over a second valid/ready handshake. Alignment, range and encoding checks are done before any `ram` access.

## Interface
- `MEM_BYTES`, 8192: size of the data `ram` in bytes. An access with `addr + size > MEM_BYTES` is out of range.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I `funct3`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_rd` in 5: load destination register.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: writeback accepts the response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_rd` out 5: destination register; 0 for stores and errors.
- `resp_err` out 2: 0 ok, 1 misaligned, 2 out of range, 3 illegal `funct3`.
- `ram_rd_addr_o` out 32, `ram_rd_en_o` out 1, `ram_rd_size_o` out 3, `ram_rd_data_i` in 32: `ram` read port.
- `ram_wd_addr_o` out 32, `ram_wd_en_o` out 1, `ram_wd_size_o` out 3, `ram_wd_data_o` out 32: `ram` write port.

## Operation
- **Size encoding** to `ram`: 1 = byte, 2 = half, 4 = word.
- **Load `funct3`**: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other value is illegal.
- **Store `funct3`**: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- **Check priority**: illegal `funct3` (3), then misaligned (1, only when `LSU_MISALIGN_TRAP_EN` is defined), then out of range (2).
- **Request register**: on acceptance, latch `we`, `funct3`, `addr`, `wdata`, `rd` and the computed error.
- **States**:
  - IDLE: `req_ready` = 1. On accept, go to ACCESS if the error is 0, else go to RESP with the error code.
  - ACCESS: `req_ready` = 0. A load asserts `ram_rd_en_o`; a store asserts `ram_wd_en_o`. Both enables are high only in this state. Always goes to RESP next.
  - RESP: `resp_valid` = 1. Go to IDLE when `resp_ready` = 1.
- **Address/size/data outputs**: `ram_*_addr_o`, `ram_*_size_o` and `ram_wd_data_o` always reflect the latched request. They are 0 after reset.
- **Load capture**: at the end of ACCESS, capture `ram_rd_data_i`. Byte loads take bits 7:0 and half loads take bits 15:0 (the `ram` returns LSB-aligned data). LB/LH sign-extend; LBU/LHU zero-extend.
- **Hold rule**: the response is held stable while `resp_valid` && !`resp_ready`. `req_valid` is ignored outside IDLE.

## Timing
- **Reset values**: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_rd` 0, `resp_err` 0, all `ram_*` outputs 0.
- **Legal access**: accept at edge N → ACCESS in cycle N+1 → `resp_valid` in cycle N+2.
- **Error access**: `resp_valid` in cycle N+1; no `ram` enable is ever asserted.
- **After response handshake**: the handshake at edge M gives `req_ready` = 1 in cycle M+1. Minimum spacing is 3 cycles per legal op and 2 per error op.
- **Store write**: `ram_wd_en_o` is high for exactly one cycle.
- **Reset mid-operation**:
  - A store whose ACCESS cycle coincides with `rst` still writes, because the `ram` write is level-sensitive.
  - Any pending or held response is discarded.
  - The block is IDLE in the cycle after the reset edge.
- **Simultaneous `req_valid` and `resp_ready` in RESP**: the request is not accepted until IDLE.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined**: a half access with `addr[0]` set, or a word access with `addr[1:0]` ≠ 0, responds with `resp_err` = 1 and no `ram` access.
- **Not defined**: alignment is not checked. Misaligned accesses go to the byte-addressed `ram` unchanged; only codes 2 and 3 remain.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 → `resp_rdata` = 0xDEADBEEF at N+2, `resp_err` = 0, `ram_wd_en_o` high exactly one cycle.
- After the SW above: LB 0x101 → 0xFFFFFFBE; LBU 0x101 → 0x000000BE; LH 0x102 → 0xFFFFDEAD; LHU 0x102 → 0x0000DEAD.
- SW 0x11223344 to 0x104, then LW 0x102:
  - macro defined → `resp_err` = 1 at N+1, `ram_rd_en_o` never high;
  - macro undefined → 0x3344DEAD at N+2.
- SW to 0x1FFE (`MEM_BYTES` = 8192) → `resp_err` = 2, no write, 0x1FFE unchanged. LW `funct3` = 011 → `resp_err` = 3.
- `resp_ready` low for 5 cycles → `resp_valid`/`resp_rdata`/`resp_rd` stable, `req_ready` = 0, `req_valid` pulses ignored. Raise `resp_ready` → `req_ready` = 1 next cycle.
- `rst` for one cycle while in RESP → next cycle `resp_valid` = 0, `req_ready` = 1, all outputs at reset values.
